// File: rtl/bnn_act_pack_if.sv
// Output word stream of bnn_act_pack: FIFO head word with valid/ready
// handshake and a flag marking the word that holds the layer's last neuron.
interface bnn_act_pack_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] out_word;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_word,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_word,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/bnn_act_pack.sv
// Binary activation packer: signed threshold compare, LSB-first word packing, 2-entry FIFO.
// Define BNN_ACT_PACK_THR_EN for per-neuron thresholds; otherwise a plain sign function.
module bnn_act_pack #(
    parameter int ACC_W  = 32,
    parameter int WORD_W = 32,
    parameter int N_OUT  = 64,
    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int POS_W = (WORD_W > 1) ? $clog2(WORD_W) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    layer_start,
    input  logic                    acc_valid,
    input  logic signed [ACC_W-1:0] acc_in,
    input  logic                    thr_we,
    input  logic [IDX_W-1:0]        thr_addr,
    input  logic signed [ACC_W-1:0] thr_data,
    bnn_act_pack_if.master          out_if,
    output logic                    busy,
    output logic                    ovf_err,
    output logic                    seq_err
);
    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] word;
    } ent_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [WORD_W-1:0]  pack_q, pack_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    ent_t               mem_q [2];
    ent_t               mem_d [2];
    logic               ovf_q, ovf_d;
    logic               seq_q, seq_d;

    logic signed [ACC_W-1:0] thr_val;
    logic [WORD_W-1:0]       word_v;
    logic                    act;
    logic                    last_v;
    logic                    done_word;
    logic                    push;
    logic                    pop;

`ifdef BNN_ACT_PACK_THR_EN
    logic signed [ACC_W-1:0] thr_q [N_OUT];

    // Not reset: thresholds survive rst and layer_start.
    always_ff @(posedge clk) begin
        if (thr_we && (int'(thr_addr) < N_OUT)) begin
            thr_q[thr_addr] <= thr_data;
        end
    end

    assign thr_val = thr_q[idx_q];
`else
    logic unused_thr;

    assign unused_thr = ^{thr_we, thr_addr, thr_data};
    assign thr_val    = '0;
`endif

    assign act       = (acc_in >= thr_val);
    assign last_v    = (idx_q == IDX_W'(N_OUT - 1));
    assign done_word = (pos_q == POS_W'(WORD_W - 1)) || last_v;
    assign pop       = (cnt_q != 2'd0) && out_if.out_ready;

    always_comb begin
        word_v        = pack_q;
        word_v[pos_q] = act;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        pack_d  = pack_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        mem_d   = mem_q;
        ovf_d   = ovf_q;
        seq_d   = seq_q;
        push    = 1'b0;
        if (layer_start) begin
            // Abort/start wins over a coincident accumulator and any pop.
            state_d = RUN;
            idx_d   = '0;
            pos_d   = '0;
            pack_d  = '0;
            cnt_d   = '0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            ovf_d   = 1'b0;
            seq_d   = 1'b0;
        end else begin
            if (acc_valid && state_q == IDLE) begin
                seq_d = 1'b1;
            end
            if (acc_valid && state_q == RUN) begin
                if (done_word) begin
                    pack_d = '0;
                    pos_d  = '0;
                    if (cnt_q != 2'd2 || pop) begin
                        push = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (last_v) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    pack_d = word_v;
                    pos_d  = pos_q + POS_W'(1);
                    idx_d  = idx_q + IDX_W'(1);
                end
            end
            if (push) begin
                mem_d[wr_q] = '{last: last_v, word: word_v};
                wr_d        = ~wr_q;
            end
            if (pop) begin
                rd_d = ~rd_q;
            end
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pos_q   <= '0;
            pack_q  <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ovf_q   <= 1'b0;
            seq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            pack_q  <= pack_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            mem_q   <= mem_d;
            ovf_q   <= ovf_d;
            seq_q   <= seq_d;
        end
    end

    // Head word is gated so an empty FIFO never shows stale data.
    assign out_if.out_valid = (cnt_q != 2'd0);
    assign out_if.out_word  = out_if.out_valid ? mem_q[rd_q].word : '0;
    assign out_if.out_last  = out_if.out_valid & mem_q[rd_q].last;
    assign busy             = (state_q == RUN);
    assign ovf_err          = ovf_q;
    assign seq_err          = seq_q;
endmodule

// File: tb/tb_bnn_act_pack.sv
// Directed bench for bnn_act_pack: a 64-neuron/32-bit instance and a
// 40-neuron/16-bit instance for partial final words and FIFO overflow.
module tb_bnn_act_pack;
    logic clk = 1'b0;
    logic rst;
    logic ls_a, av_a, ls_b, av_b;
    logic signed [31:0] acc;
    logic thr_we;
    logic [5:0] thr_addr;
    logic signed [31:0] thr_data;
    logic busy_a, ovf_a, seq_a;
    logic busy_b, ovf_b, seq_b;

    int checks = 0;
    int errors = 0;

    logic [32:0] qa[$];
    logic [16:0] qb[$];

    bnn_act_pack_if #(.WORD_W(32)) ifa ();
    bnn_act_pack_if #(.WORD_W(16)) ifb ();

    bnn_act_pack #(.ACC_W(32), .WORD_W(32), .N_OUT(64)) ua (
        .clk(clk), .rst(rst), .layer_start(ls_a), .acc_valid(av_a),
        .acc_in(acc), .thr_we(thr_we), .thr_addr(thr_addr),
        .thr_data(thr_data), .out_if(ifa), .busy(busy_a),
        .ovf_err(ovf_a), .seq_err(seq_a)
    );

    bnn_act_pack #(.ACC_W(32), .WORD_W(16), .N_OUT(40)) ub (
        .clk(clk), .rst(rst), .layer_start(ls_b), .acc_valid(av_b),
        .acc_in(acc), .thr_we(thr_we), .thr_addr(thr_addr),
        .thr_data(thr_data), .out_if(ifb), .busy(busy_b),
        .ovf_err(ovf_b), .seq_err(seq_b)
    );

    always #5 clk = ~clk;

    // Record every word actually handed to the consumer.
    always @(negedge clk) begin
        if (ifa.out_valid && ifa.out_ready) qa.push_back({ifa.out_last, ifa.out_word});
        if (ifb.out_valid && ifb.out_ready) qb.push_back({ifb.out_last, ifb.out_word});
    end

    typedef struct {
        string              name;
        logic signed [31:0] ev;
        logic signed [31:0] od;
        logic [31:0]        w0;
        logic [31:0]        w1;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a();
        ls_a = 1'b1;
        tick();
        ls_a = 1'b0;
    endtask

    task automatic start_b();
        ls_b = 1'b1;
        tick();
        ls_b = 1'b0;
    endtask

    task automatic acc_a(input logic signed [31:0] v);
        acc = v;
        av_a = 1'b1;
        tick();
        av_a = 1'b0;
    endtask

    task automatic acc_b(input logic signed [31:0] v);
        acc = v;
        av_b = 1'b1;
        tick();
        av_b = 1'b0;
    endtask

    task automatic run_a(input logic signed [31:0] ev, input logic signed [31:0] od);
        for (int i = 0; i < 64; i++) acc_a((i % 2 == 0) ? ev : od);
    endtask

    task automatic wr_thr(input logic [5:0] a, input logic signed [31:0] d);
        thr_we = 1'b1;
        thr_addr = a;
        thr_data = d;
        tick();
        thr_we = 1'b0;
    endtask

    task automatic chk_two(input string nm, input logic [31:0] w0, input logic [31:0] w1);
        chk({nm, " count"}, 64'(qa.size()), 64'd2);
        if (qa.size() >= 2) begin
            chk({nm, " word0"}, 64'(qa[0]), {31'd0, 1'b0, w0});
            chk({nm, " word1"}, 64'(qa[1]), {31'd0, 1'b1, w1});
        end
    endtask

    initial begin
        tbl[0] = '{"alt_p5_m5", 5, -5, 32'h5555_5555, 32'h5555_5555};
        tbl[1] = '{"alt_m5_p5", -5, 5, 32'hAAAA_AAAA, 32'hAAAA_AAAA};
        tbl[2] = '{"all_zero", 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[3] = '{"all_m1", -1, -1, 32'h0000_0000, 32'h0000_0000};
        tbl[4] = '{"extremes", 32'sh7FFF_FFFF, 32'sh8000_0000, 32'h5555_5555, 32'h5555_5555};
        tbl[5] = '{"m1_zero", -1, 0, 32'hAAAA_AAAA, 32'hAAAA_AAAA};

        rst = 1'b1;
        ls_a = 1'b0; av_a = 1'b0; ls_b = 1'b0; av_b = 1'b0;
        acc = '0; thr_we = 1'b0; thr_addr = '0; thr_data = '0;
        ifa.out_ready = 1'b1;
        ifb.out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst valid", 64'(ifa.out_valid), 64'd0);
        chk("rst word", 64'(ifa.out_word), 64'd0);
        chk("rst last", 64'(ifa.out_last), 64'd0);
        chk("rst busy", 64'(busy_a), 64'd0);
        chk("rst ovf", 64'(ovf_a), 64'd0);
        chk("rst seq", 64'(seq_a), 64'd0);
        chk("rst b valid", 64'(ifb.out_valid), 64'd0);

`ifdef BNN_ACT_PACK_THR_EN
        for (int i = 0; i < 64; i++) wr_thr(6'(i), 0);
`endif

        for (int v = 0; v < 6; v++) begin
            qa.delete();
            start_a();
            chk({tbl[v].name, " busy_run"}, 64'(busy_a), 64'd1);
            run_a(tbl[v].ev, tbl[v].od);
            tick();
            chk_two(tbl[v].name, tbl[v].w0, tbl[v].w1);
            chk({tbl[v].name, " busy_end"}, 64'(busy_a), 64'd0);
        end

        // First word appears one cycle after its completing accumulator.
        qa.delete();
        start_a();
        for (int i = 0; i < 31; i++) acc_a(1);
        chk("lat before", 64'(ifa.out_valid), 64'd0);
        acc_a(1);
        chk("lat valid", 64'(ifa.out_valid), 64'd1);
        chk("lat word", 64'(ifa.out_word), 64'hFFFF_FFFF);

        // Abort mid-layer then a full clean layer.
        start_a();
        for (int i = 0; i < 10; i++) acc_a(5);
        qa.delete();
        start_a();
        chk("abort valid", 64'(ifa.out_valid), 64'd0);
        chk("abort busy", 64'(busy_a), 64'd1);
        chk("abort flags", 64'({ovf_a, seq_a}), 64'd0);
        run_a(5, -5);
        tick();
        chk_two("abort", 32'h5555_5555, 32'h5555_5555);

        // acc_valid in IDLE, then layer_start coinciding with acc_valid.
        qa.delete();
        acc_a(5);
        chk("idle seq", 64'(seq_a), 64'd1);
        chk("idle valid", 64'(ifa.out_valid), 64'd0);
        acc = -5;
        av_a = 1'b1;
        ls_a = 1'b1;
        tick();
        av_a = 1'b0;
        ls_a = 1'b0;
        chk("start clr seq", 64'(seq_a), 64'd0);
        run_a(5, -5);
        tick();
        chk("coinc seq", 64'(seq_a), 64'd0);
        chk_two("coinc", 32'h5555_5555, 32'h5555_5555);

        // Backpressure: both words held, head stable.
        ifa.out_ready = 1'b0;
        start_a();
        run_a(-5, 5);
        chk("bp valid", 64'(ifa.out_valid), 64'd1);
        chk("bp head", 64'({ifa.out_last, ifa.out_word}), {31'd0, 1'b0, 32'hAAAA_AAAA});
        chk("bp ovf", 64'(ovf_a), 64'd0);
        repeat (3) tick();
        chk("bp stable", 64'({ifa.out_last, ifa.out_word}), {31'd0, 1'b0, 32'hAAAA_AAAA});
        qa.delete();
        ifa.out_ready = 1'b1;
        repeat (3) tick();
        chk_two("bp drain", 32'hAAAA_AAAA, 32'hAAAA_AAAA);
        chk("bp empty word", 64'(ifa.out_word), 64'd0);

        // 40 neurons into 16-bit words: partial final word.
        qb.delete();
        start_b();
        for (int i = 0; i < 40; i++) acc_b(1);
        tick();
        chk("b count", 64'(qb.size()), 64'd3);
        if (qb.size() >= 3) begin
            chk("b w0", 64'(qb[0]), {47'd0, 1'b0, 16'hFFFF});
            chk("b w1", 64'(qb[1]), {47'd0, 1'b0, 16'hFFFF});
            chk("b w2", 64'(qb[2]), {47'd0, 1'b1, 16'h00FF});
        end
        chk("b busy", 64'(busy_b), 64'd0);

        // Overflow: third word dropped on a full FIFO.
        ifb.out_ready = 1'b0;
        start_b();
        for (int i = 0; i < 40; i++) acc_b(1);
        chk("b ovf", 64'(ovf_b), 64'd1);
        chk("b ovf busy", 64'(busy_b), 64'd0);
        chk("b ovf head", 64'({ifb.out_last, ifb.out_word}), {47'd0, 1'b0, 16'hFFFF});
        qb.delete();
        ifb.out_ready = 1'b1;
        repeat (3) tick();
        chk("b ovf count", 64'(qb.size()), 64'd2);
        if (qb.size() >= 2) chk("b ovf w1", 64'(qb[1]), {47'd0, 1'b0, 16'hFFFF});
        chk("b ovf sticky", 64'(ovf_b), 64'd1);
        start_b();
        chk("b ovf clr", 64'(ovf_b), 64'd0);

`ifdef BNN_ACT_PACK_THR_EN
        wr_thr(6'd3, 10);
        start_a();
        for (int i = 0; i < 32; i++) acc_a((i == 3) ? 10 : 0);
        chk("thr eq", 64'(ifa.out_word), 64'hFFFF_FFFF);
        start_a();
        for (int i = 0; i < 32; i++) acc_a((i == 3) ? 9 : 0);
        chk("thr below", 64'(ifa.out_word), 64'hFFFF_FFF7);
        start_a();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
